// File: rtl/data_memory.sv
// Purpose: off-chip data memory model, 512 x 256-bit lines behind the data cache.
// Latency: request accepted on edge E0, access on E0+LATENCY, one-cycle ack in the cycle after.
// Backpressure: one request at a time; enable_i held until ack, min spacing LATENCY+2 edges.
// Optional feature: define DMEM_RANGE_CHECK_EN to flag addresses with nonzero addr_i[31:14].
module data_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int IDX_LO = 5;
    localparam int IDX_HI = IDX_LO + IDX_W;
    localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // Line storage; preloaded and inspected hierarchically by the system bench.
    reg [DATA_W-1:0] memory [0:DEPTH-1];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_dat;
    logic               r_wr;
    logic               r_oor;
    logic               w_accept;
    logic               w_access;
    logic               w_oor_req;
    logic               w_unused_addr;

`ifdef DMEM_RANGE_CHECK_EN
    // Any upper address bit set means the request falls outside the 16 KB window.
    assign w_oor_req     = |addr_i[ADDR_W-1:IDX_HI];
    assign w_unused_addr = ^addr_i[IDX_LO-1:0];
`else
    // Upper address bits are ignored, so the index wraps modulo DEPTH.
    assign w_oor_req     = 1'b0;
    assign w_unused_addr = ^{addr_i[ADDR_W-1:IDX_HI], addr_i[IDX_LO-1:0]};
`endif

    // State, latency counter and latched request.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dat   <= '0;
            r_wr    <= 1'b0;
            r_oor   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx <= addr_i[IDX_HI-1:IDX_LO];
                r_dat <= data_i;
                r_wr  <= write_i;
                r_oor <= w_oor_req;
            end
        end
    end

    // Next-state logic: accept in IDLE, count in BUSY, single ACK cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable_i) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(LATENCY - 1)) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                // enable_i is deliberately ignored here; a held request is taken in IDLE.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs: ack pulse, read data capture, range-error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_o  <= 1'b0;
            data_o <= '0;
            err_o  <= 1'b0;
        end else begin
            ack_o <= w_access;
            err_o <= w_access & r_oor;
            if (w_access && !r_wr) begin
                data_o <= r_oor ? '0 : memory[r_idx];
            end
        end
    end

    // Line write on the access edge; a reset on that same edge aborts it.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_access && r_wr && !r_oor) begin
            memory[r_idx] <= r_dat;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed scenarios followed by random reads/writes.
// Expected responses are queued at issue time and checked by an independent monitor.
// Summary line reports total comparisons and failures.
module tb_data_memory;

    localparam int LAT = 10;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic         clk_i    = 1'b0;
    logic         rst_i    = 1'b0;
    logic [31:0]  addr_i   = '0;
    logic [255:0] data_i   = '0;
    logic         enable_i = 1'b0;
    logic         write_i  = 1'b0;
    logic         ack_o;
    logic [255:0] data_o;
    logic         err_o;

    data_memory dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [255:0] dat;
        logic         err;
        int           acc;
    } exp_t;
    exp_t sbq[$];

    logic [255:0] model [512];
    logic [255:0] last_rd;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] pat(input logic [15:0] base, input logic [15:0] step);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[255-16*i -: 16] = base + step * 16'(i);
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: pops one expectation per ack and checks data, error, latency, pulse width.
    logic prev_ack = 1'b0;
    always @(negedge clk_i) begin
        exp_t e;
        if (ack_o === 1'b1) begin
            chk("ack_single_cycle", 256'(prev_ack), 256'(0));
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("data_o", data_o, e.dat);
                chk("err_o", 256'(err_o), 256'(e.err));
                chk("ack_latency", 256'(cyc - e.acc), 256'(LAT));
            end
        end
        prev_ack = ack_o;
    end

    // Issue one request from a negedge and wait for its ack (bounded).
    // b2b=1 means the DUT is currently in its ack cycle, so acceptance is one edge later.
    task automatic issue(input logic [31:0] a, input logic [255:0] d, input bit wr, input bit b2b);
        exp_t         e;
        int           idx;
        bit           oor;
        bit           got;
        logic [255:0] oldv;
        logic [255:0] newv;
        idx  = int'(a[13:5]);
        oor  = RC && (a[31:14] != 0);
        oldv = model[idx];
        if (wr) begin
            if (!oor) model[idx] = d;
            e.dat = last_rd;
        end else begin
            last_rd = oor ? 256'd0 : model[idx];
            e.dat   = last_rd;
        end
        newv  = model[idx];
        e.err = oor;
        e.acc = b2b ? cyc + 2 : cyc + 1;
        sbq.push_back(e);
        addr_i   = a;
        data_i   = d;
        write_i  = wr;
        enable_i = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 4 * LAT && !got; n++) begin
            @(negedge clk_i);
            if (cyc >= e.acc) begin
                if (wr) chk("mem_update_timing", dut.memory[idx], ack_o ? newv : oldv);
                if (ack_o) got = 1'b1;
                else begin
                    // Inputs are already latched; disturbing them must not matter.
                    addr_i  = $urandom;
                    data_i  = rnd256();
                    write_i = $urandom_range(0, 1);
                end
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=no_ack expected=ack addr=%h", a);
            void'(sbq.pop_back());
        end
    endtask

    task automatic idle();
        enable_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk_i);
    endtask

    initial begin
        int t1;
        logic [255:0] wpat;
        logic [31:0]  a;

        // Preload DUT and model with identical contents.
        for (int i = 0; i < 512; i++) model[i] = rnd256();
        model[0]  = pat(16'h0000, 16'h1111);
        model[2]  = pat(16'hECFA, 16'h0000);
        model[16] = 256'h0123456789ABCDEFFEDCBA98765432100123456789ABCDEFFEDCBA9876543210;
        model[32] = pat(16'h0000, 16'h1001);
        for (int i = 0; i < 512; i++) dut.memory[i] = model[i];
        last_rd = '0;

        // Reset state.
        repeat (3) @(negedge clk_i);
        chk("reset_ack_o", 256'(ack_o), 256'(0));
        chk("reset_data_o", data_o, 256'd0);
        chk("reset_err_o", 256'(err_o), 256'(0));
        rst_i = 1'b1;
        @(negedge clk_i);

        // Read preloaded line 0.
        issue(32'h0000_0000, '0, 1'b0, 1'b0);
        idle();

        // Write inverted pattern to line 17 and read it back.
        wpat = ~pat(16'h0000, 16'h0110);
        issue(32'h0000_0220, wpat, 1'b1, 1'b0);
        idle();
        issue(32'h0000_0220, '0, 1'b0, 1'b0);
        idle();
        chk("line17_readback", data_o, ~pat(16'h0000, 16'h0110));

        // Low address bits are ignored.
        issue(32'h0000_005F, '0, 1'b0, 1'b0);
        idle();

        // Reset in the middle of a write aborts it.
        addr_i   = 32'h0000_0400;
        data_i   = rnd256();
        write_i  = 1'b1;
        enable_i = 1'b1;
        repeat (5) @(negedge clk_i);
        rst_i    = 1'b0;
        enable_i = 1'b0;
        @(negedge clk_i);
        rst_i   = 1'b1;
        last_rd = '0;
        repeat (LAT + 5) @(negedge clk_i);
        chk("abort_no_ack", 256'(ack_o), 256'(0));
        chk("abort_mem32", dut.memory[32], pat(16'h0000, 16'h1001));
        chk("abort_data_o", data_o, 256'd0);
        chk("abort_err_o", 256'(err_o), 256'(0));

        // Back-to-back reads with enable held.
        issue(32'h0000_0000, '0, 1'b0, 1'b0);
        t1 = cyc;
        issue(32'h0000_0200, '0, 1'b0, 1'b1);
        chk("b2b_spacing", 256'(cyc - t1), 256'(LAT + 2));
        chk("b2b_line16", data_o, 256'h0123456789ABCDEFFEDCBA98765432100123456789ABCDEFFEDCBA9876543210);
        idle();

        // Address at the 16 KB boundary.
        issue(32'h0000_4000, '0, 1'b0, 1'b0);
        idle();
        issue(32'h0000_4000, rnd256(), 1'b1, 1'b0);
        idle();
        issue(32'h0000_0000, '0, 1'b0, 1'b0);
        idle();
        chk("line0_after_4000_write", dut.memory[0], model[0]);

        // Random traffic, with and without upper address bits, sometimes back-to-back.
        for (int k = 0; k < 60; k++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[31:14] = '0;
            issue(a, rnd256(), $urandom_range(0, 1) == 1, 1'b0);
            while ($urandom_range(0, 2) == 0 && k < 59) begin
                a = $urandom;
                if ($urandom_range(0, 1) == 1) a[31:14] = '0;
                issue(a, rnd256(), $urandom_range(0, 1) == 1, 1'b1);
                k++;
            end
            idle();
        end

        repeat (LAT + 4) @(negedge clk_i);
        chk("scoreboard_drained", 256'(sbq.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
